// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and sizing constants.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder used as the serial adder's arithmetic core.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: captures A/B/cin on accept, adds one bit per cycle LSB first,
// and publishes {cout,sum} only on entry to DONE.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 32'sd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'sd1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-2:0] res_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic [CW-1:0]    cnt_r;
  logic             fa_sum_s;
  logic             fa_carry_s;
  logic             accept_s;
  logic             last_s;

  fa_cell u_fa (
    .a    (a_r[0]),
    .b    (b_r[0]),
    .cin  (carry_r),
    .s    (fa_sum_s),
    .cout (fa_carry_s)
  );

  assign ready    = (state_r == IDLE) || (state_r == DONE);
  assign busy     = (state_r == SHIFT);
  assign done     = (state_r == DONE);
  assign accept_s = ready & start;
  assign last_s   = (cnt_r == CNT_LAST);
  assign sum      = sum_r;
  assign cout     = cout_r;

  // The newest sum bit enters at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
  assign res_nxt_s = {fa_sum_s, res_r};

  // Next-state decode; start is only honoured while ready.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = SHIFT;
        else       state_nxt_s = IDLE;
      end
      SHIFT: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = SHIFT;
      end
      DONE: begin
        if (start) state_nxt_s = SHIFT;
        else       state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Operand shifters, running carry, partial result and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {(WIDTH-1){1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else if (accept_s) begin
      a_r     <= a;
      b_r     <= b;
      res_r   <= {(WIDTH-1){1'b0}};
      carry_r <= cin;
      cnt_r   <= {CW{1'b0}};
    end else if (state_r == SHIFT) begin
      a_r     <= {1'b0, a_r[WIDTH-1:1]};
      b_r     <= {1'b0, b_r[WIDTH-1:1]};
      res_r   <= res_nxt_s[WIDTH-1:1];
      carry_r <= fa_carry_s;
      cnt_r   <= cnt_r + CNT_ONE;
    end else begin
      a_r     <= a_r;
      b_r     <= b_r;
      res_r   <= res_r;
      carry_r <= carry_r;
      cnt_r   <= cnt_r;
    end
  end

  // Visible result: committed only on the final shift so it never shows partial sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r  <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
    end else if ((state_r == SHIFT) && last_s) begin
      sum_r  <= res_nxt_s;
      cout_r <= fa_carry_s;
    end else begin
      sum_r  <= sum_r;
      cout_r <= cout_r;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table plus scoreboard,
// with hand-written sequences for ignored start, abort, reset priority and back-to-back.
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[9];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_sum", 32'(sum), 32'(mon_e.s));
        chk("sb_cout", 32'(cout), 32'(mon_e.c));
      end
    end
  end

  // Called at the mid-cycle point of the accept cycle (cycle 0); returns in cycle W+1.
  task automatic run_shift(input string tag);
    logic [7:0] hs;
    logic       hc;
    hs = sum;
    hc = cout;
    @(negedge clk);
    start = 1'b0;
    a     = ~a;
    b     = ~b;
    cin   = ~cin;
    for (int k = 1; k <= W; k++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_ready"}, 32'(ready), 32'd0);
      chk({tag, "_early_done"}, 32'(done), 32'd0);
      chk({tag, "_sum_hold"}, 32'(sum), 32'(hs));
      chk({tag, "_cout_hold"}, 32'(cout), 32'(hc));
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_done_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                       input logic [7:0] es, input logic ec, input logic push);
    exp_t e;
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    chk("accept_ready", 32'(ready), 32'd1);
    if (push) begin
      e.s = es;
      e.c = ec;
      sbq.push_back(e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, c: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1};
    vecs[2] = '{a: 8'h3C, b: 8'h42, cin: 1'b1, s: 8'h7F, c: 1'b0};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, c: 1'b1};
    vecs[4] = '{a: 8'h55, b: 8'hAA, cin: 1'b0, s: 8'hFF, c: 1'b0};
    vecs[5] = '{a: 8'h12, b: 8'h34, cin: 1'b1, s: 8'h47, c: 1'b0};
    vecs[6] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, s: 8'h00, c: 1'b1};
    vecs[7] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, c: 1'b0};
    vecs[8] = '{a: 8'hC3, b: 8'h3D, cin: 1'b0, s: 8'h00, c: 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table: inputs are inverted right after accept, so results also prove operand capture.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, 1'b1);
      run_shift($sformatf("vec%0d", i));
      @(negedge clk);
      chk("vec_idle_done", 32'(done), 32'd0);
      chk("vec_idle_ready", 32'(ready), 32'd1);
    end

    // start during SHIFT is ignored.
    issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    for (int k = 3; k <= W; k++) begin
      chk("ign_busy", 32'(busy), 32'd1);
      chk("ign_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_done9", 32'(done), 32'd1);
    @(negedge clk);
    chk("ign_single_done", 32'(done), 32'd0);
    chk("ign_idle_busy", 32'(busy), 32'd0);

    // Reset in cycle 4 aborts the operation.
    issue(8'h3C, 8'h42, 1'b1, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end

    // Reset wins over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    @(negedge clk);
    chk("rstprio_busy", 32'(busy), 32'd0);
    chk("rstprio_ready", 32'(ready), 32'd1);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rstprio_busy2", 32'(busy), 32'd0);

    // Back-to-back: second start accepted in the done cycle.
    issue(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1);
    run_shift("b2b1");
    chk("b2b1_sum", 32'(sum), 32'h02);
    chk("b2b1_cout", 32'(cout), 32'd0);
    issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_shift("b2b2");
    chk("b2b2_sum", 32'(sum), 32'h00);
    chk("b2b2_cout", 32'(cout), 32'd1);
    @(negedge clk);
    chk("b2b_end_done", 32'(done), 32'd0);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter WIDTH SHALL default to 8 (operand width, legal range 2..32).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to add; sampled only when ready=1.
REQ-006 a  input  WIDTH  operand A; captured on accept.
REQ-007 b  input  WIDTH  operand B; captured on accept.
REQ-008 cin  input  1  carry-in; captured on accept.
REQ-009 ready  output  1  high in IDLE and DONE; start is accepted only then.
REQ-010 busy  output  1  high in SHIFT.
REQ-011 done  output  1  one-cycle pulse; sum/cout are valid.
REQ-012 sum  output  WIDTH  registered result; holds until the next completion.
REQ-013 cout  output  1  registered final carry; holds like sum.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-015 IDLE->SHIFT on start=1: load A/B shift registers and carry flop (carry=cin), clear bit counter.
REQ-016 Each SHIFT cycle SHALL feed A[0], B[0] and carry into a 1-bit full adder.
REQ-017 Each SHIFT cycle SHALL shift the adder's sum bit into the result register MSB-side, so bit order is LSB first.
REQ-018 Each SHIFT cycle SHALL update carry, shift A/B right and increment the counter.
REQ-019 SHIFT->DONE after exactly WIDTH SHIFT cycles (counter reaches WIDTH-1); on that edge, commit sum and cout outputs.
REQ-020 DONE SHALL last one cycle with done=1, then go to IDLE, or to SHIFT if start=1 (back-to-back accept).
REQ-021 Latency: if start is sampled in cycle 0, done SHALL be high in cycle WIDTH+1 and only then.
REQ-022 start during SHIFT SHALL be ignored, with no effect on operands, result or timing.
REQ-023 Input changes after accept SHALL NOT affect the result.
REQ-024 sum/cout SHALL change only on the edge entering DONE; they are never partially updated as visible outputs.
REQ-025 Result SHALL equal {cout,sum} = a + b + cin modulo 2^(WIDTH+1), with no overflow flag.
REQ-026 ready, busy and done SHALL be decoded from state; ready and busy are mutually exclusive.

Reset
REQ-027 rst=1 SHALL force IDLE; sum=0, cout=0, done=0, busy=0, ready=1; carry, counter and shift registers SHALL clear.
REQ-028 rst during SHIFT or DONE SHALL abort: no done pulse, outputs 0 next cycle.
REQ-029 rst and start high together SHALL give rst priority; the start is not accepted.

Structure
REQ-030 Shared package serial_add_pkg SHALL hold the state enum, the WIDTH default and the counter width constant (clog2 of WIDTH).
REQ-031 The 1-bit full adder SHALL be the sub-module fa_cell (purely combinational: a, b, cin -> s, cout), instantiated once.
REQ-032 Control and datapath registers SHALL live in serial_add_ctrl.

Verification (WIDTH=8)
REQ-033 a=0x00, b=0x00, cin=0, start in cycle 0 -> done only in cycle 9; sum=0x00, cout=0; busy high in cycles 1-8.
REQ-034 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple).
REQ-035 a=0x3C, b=0x42, cin=1 -> sum=0x7F, cout=0; change a to 0xFF in cycle 2 -> result unchanged.
REQ-036 Start 0x10+0x20 with cin=0; in cycle 3, start=1 with a=0xFF, b=0xFF -> ignored; sum=0x30, cout=0, single done in cycle 9.
REQ-037 rst=1 in cycle 4 of an operation -> cycle 5: ready=1, busy=0, sum=0x00, cout=0; no done pulse ever.
REQ-038 Start 0x01+0x01, then start 0x80+0x80 in the done cycle (9) -> done in cycles 9 and 18.
REQ-039 For REQ-038, the result registers SHALL read sum=0x02, cout=0 at cycle 9 and sum=0x00, cout=1 at cycle 18.
